gshare_history_unit: RTL and testbench
======================================

# gshare_history_unit

Front end of the gshare branch predictor; sits directly upstream of the pattern history table (PHT). It keeps the speculative global history register (GHR) and forms the PHT index as PC XOR GHR. It drives the PHT read port for fetch-time predictions and arbitrates that port for in-order resolution updates. On a mispredict it repairs the GHR from a per-branch checkpoint FIFO.

## Interface
- HISTORY_LEN, 12: GHR width and PHT index width; must match the PHT.
- DEPTH, 8: maximum in-flight unresolved branches (checkpoint FIFO depth); power of two, ≥2.
- clk  input  1  sole clock, rising edge.
- rst_b  input  1  one clock; reset is synchronous and active-high. The port name follows the codebase; an asserted value of 1 resets the block.
- pred_valid  input  1  fetch presents a conditional branch for prediction.
- pred_pc  input  HISTORY_LEN  PC bits [HISTORY_LEN+1:2] of the branch.
- pred_ready  output  1  prediction accepted this cycle when pred_valid && pred_ready.
- pred_taken  output  1  predicted direction; valid whenever pred_ready is 1.
- resolve_valid  input  1  execute resolves the oldest in-flight branch.
- resolve_taken  input  1  actual direction.
- mispredict  output  1  registered one-cycle pulse: the resolved branch was mispredicted and younger state was flushed.
- inflight  output  $clog2(DEPTH)+1  occupancy of the checkpoint FIFO.
- pht_index  output  HISTORY_LEN  to PHT branch_history.
- pht_write_en  output  1  to PHT write_en.
- pht_taken  output  1  to PHT taken.
- pht_counter  input  2  from PHT saturating_counter, read combinationally.

## Operation
- Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 11 weakly-taken, 10 strongly-taken. Predicted taken = pht_counter[1].
- Port arbitration: resolve has priority.
  - pred_ready = !rst_b && !resolve_valid && (inflight < DEPTH).
  - When resolve_valid is 1 and the FIFO is non-empty: pht_index = head.index.
  - Otherwise: pht_index = pred_pc ^ ghr.
- Predict (accept cycle):
  - Push {index = pred_pc^ghr, ghr_snap = ghr, pred = pht_counter[1]}.
  - ghr <= {ghr[HISTORY_LEN-2:0], pht_counter[1]}.
- Resolve with FIFO non-empty:
  - pht_write_en = 1, pht_taken = resolve_taken, head is popped.
  - If resolve_taken != head.pred: flush the whole FIFO (inflight <= 0), set ghr <= {head.ghr_snap[HISTORY_LEN-2:0], resolve_taken}, and set mispredict <= 1 on the next edge.
  - If correct: GHR unchanged, since it already holds the outcome.
- Resolve with FIFO empty: ignored. pht_write_en = 0, no state change.
- pht_write_en = 0 whenever rst_b = 1.

## Timing
- Reset values: ghr = 0, FIFO empty, inflight = 0, mispredict = 0, pred_ready = 0, pht_write_en = 0.
- Reset is sampled at the edge. Reset mid-operation discards all checkpoints, and no PHT write occurs in the reset cycle.
- Prediction latency: 0 cycles. pred_taken is combinational from pred_pc, the GHR and the PHT.
- Back-to-back accepts are allowed. The second accept uses the GHR already shifted by the first.
- A PHT update is written at the resolve edge. A lookup to the same index in the next cycle sees the updated counter.
- Full (inflight == DEPTH): pred_ready = 0. A simultaneous resolve frees a slot, but accept resumes only the cycle after.
- Pointers wrap modulo DEPTH. inflight distinguishes full from empty.
- mispredict asserts exactly one cycle after the mispredicted resolve. pred_ready may be 1 in that same cycle, using the repaired GHR.

## Structure
- Shared package bp_pkg holds:
  - HISTORY_LEN
  - the four counter encoding localparams
  - typedef struct ckpt_t {index, ghr_snap, pred}
  - the function next_ghr(ghr, bit)
- The PHT imports the same constants.
- One sub-module, bp_ckpt_fifo: a synchronous FIFO of ckpt_t with push, pop, flush (flush wins over push), head output, and count. This unit holds the GHR, the arbitration logic and the mispredict register.

## Test plan
- PHT backdoor-initialised to 01 (weakly-not-taken) before each test; the PHT itself has no reset.
- Reset then predict pc=0x0A3, ghr=0 → pht_index=0x0A3, pred_taken=0, ghr becomes 0x000, inflight=1.
- Resolve taken for that branch → pht_write_en=1 at index 0x0A3 with taken=1, counter becomes 11, mispredict pulses next cycle, ghr=0x001, inflight=0.
- Four accepted predictions, then a mispredict on the oldest → inflight 4→0, ghr = {snap[10:0], actual}, younger three never written to the PHT.
- Fill to DEPTH=8 → pred_ready=0. One correct resolve → inflight=7, pred_ready=1 on the following cycle.
- resolve_valid and pred_valid in the same cycle → only the PHT write occurs, the prediction stalls, and pht_index equals the head index.
- Resolve with an empty FIFO → no write, no mispredict, state unchanged. Assert rst_b with 3 in flight → next cycle inflight=0, ghr=0, pred_ready=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared gshare predictor definitions: history width, 2-bit counter
// encodings, the per-branch checkpoint record and the GHR shift helper.
package bp_pkg;

   localparam int HISTORY_LEN = 12;

   // Counter encoding; bit 1 alone gives the predicted direction
   localparam logic [1:0] CNT_STRONG_NT = 2'b00;
   localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
   localparam logic [1:0] CNT_WEAK_T    = 2'b11;
   localparam logic [1:0] CNT_STRONG_T  = 2'b10;

   // Everything needed to update the PHT and repair the GHR at resolve time
   typedef struct packed {
      logic [HISTORY_LEN-1:0] index;
      logic [HISTORY_LEN-1:0] ghr_snap;
      logic                   pred;
   } ckpt_t;

   // Shift one outcome into the youngest end of a history value
   function automatic logic [HISTORY_LEN-1:0] next_ghr(input logic [HISTORY_LEN-1:0] ghr,
                                                       input logic outcome);
      return {ghr[HISTORY_LEN-2:0], outcome};
   endfunction

   // Predicted direction for a counter value
   function automatic logic counter_taken(input logic [1:0] cnt);
      logic taken;
      unique case (cnt)
         CNT_STRONG_NT, CNT_WEAK_NT: taken = 1'b0;
         CNT_WEAK_T, CNT_STRONG_T:   taken = 1'b1;
         default:                    taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/gshare_history_unit_if.sv
// Fetch / execute / PHT signal bundle around the gshare history unit.
// The slave modport is the unit itself; master is its environment.
interface gshare_history_unit_if #(parameter int DEPTH = 8);
   import bp_pkg::*;

   logic                   pred_valid;
   logic [HISTORY_LEN-1:0] pred_pc;
   logic                   pred_ready;
   logic                   pred_taken;
   logic                   resolve_valid;
   logic                   resolve_taken;
   logic                   mispredict;
   logic [$clog2(DEPTH):0] inflight;
   logic [HISTORY_LEN-1:0] pht_index;
   logic                   pht_write_en;
   logic                   pht_taken;
   logic [1:0]             pht_counter;

   modport slave (
      input  pred_valid, pred_pc, resolve_valid, resolve_taken, pht_counter,
      output pred_ready, pred_taken, mispredict, inflight, pht_index, pht_write_en, pht_taken
   );

   modport master (
      output pred_valid, pred_pc, resolve_valid, resolve_taken, pht_counter,
      input  pred_ready, pred_taken, mispredict, inflight, pht_index, pht_write_en, pht_taken
   );

endinterface

// File: rtl/bp_ckpt_fifo.sv
// Checkpoint FIFO: one entry per in-flight branch, oldest at the head.
// Flush empties it in one cycle and beats a same-cycle push.
module bp_ckpt_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  ckpt_t                  data_i,
   output ckpt_t                  head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_COUNT = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   COUNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE    = 1;

   ckpt_t            mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign doPush  = push_i && !flush_i && (count_q != FULL_COUNT);
   assign doPop   = pop_i && !flush_i && (count_q != '0);
   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

   // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of two
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
         if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
         unique case ({doPush, doPop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/occupancy registers; reset discards every checkpoint
   always_ff @(posedge clk) begin
      if (rst_b) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (doPush && !rst_b) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/gshare_history_unit.sv
// gshare front end: speculative GHR, PC^GHR index formation, PHT port
// arbitration (resolve wins) and GHR repair from per-branch checkpoints.
module gshare_history_unit
   import bp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_b,
   gshare_history_unit_if.slave  bus
);

   localparam logic [$clog2(DEPTH):0] FULL_COUNT = DEPTH[$clog2(DEPTH):0];

   logic [HISTORY_LEN-1:0] ghr_q, ghr_d;
   logic                   mispredict_q, mispredict_d;
   logic [HISTORY_LEN-1:0] predIndex;
   logic                   predTaken;
   logic                   predReady;
   logic                   acceptPred;
   logic                   doResolve;
   logic                   isMispredict;
   ckpt_t                  headCkpt;
   ckpt_t                  pushCkpt;
   logic [$clog2(DEPTH):0] count;

   assign predIndex    = bus.pred_pc ^ ghr_q;
   assign predTaken    = counter_taken(bus.pht_counter);
   assign predReady    = !rst_b && !bus.resolve_valid && (count < FULL_COUNT);
   assign acceptPred   = bus.pred_valid && predReady;
   assign doResolve    = !rst_b && bus.resolve_valid && (count != '0);
   assign isMispredict = doResolve && (bus.resolve_taken != headCkpt.pred);

   assign pushCkpt = '{index: predIndex, ghr_snap: ghr_q, pred: predTaken};

   assign bus.pred_ready   = predReady;
   assign bus.pred_taken   = predTaken;
   assign bus.mispredict   = mispredict_q;
   assign bus.inflight     = count;
   assign bus.pht_index    = (bus.resolve_valid && (count != '0)) ? headCkpt.index : predIndex;
   assign bus.pht_write_en = doResolve;
   assign bus.pht_taken    = bus.resolve_taken;

   bp_ckpt_fifo #(.DEPTH(DEPTH)) u_ckpt_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push_i  (acceptPred),
      .pop_i   (doResolve),
      .flush_i (isMispredict),
      .data_i  (pushCkpt),
      .head_o  (headCkpt),
      .count_o (count)
   );

   // GHR next-state: repair from the head snapshot on mispredict, else shift in the prediction
   always_comb begin
      ghr_d        = ghr_q;
      mispredict_d = isMispredict;
      if (isMispredict) begin
         ghr_d = next_ghr(headCkpt.ghr_snap, bus.resolve_taken);
      end else if (acceptPred) begin
         ghr_d = next_ghr(ghr_q, predTaken);
      end
   end

   // GHR and one-cycle mispredict pulse registers
   always_ff @(posedge clk) begin
      if (rst_b) begin
         ghr_q        <= '0;
         mispredict_q <= 1'b0;
      end else begin
         ghr_q        <= ghr_d;
         mispredict_q <= mispredict_d;
      end
   end

endmodule

// File: tb/tb_gshare_history_unit.sv
// Directed bench for gshare_history_unit with a behavioural PHT attached.
module tb_gshare_history_unit;
   import bp_pkg::*;

   localparam int DEPTH = 8;

   logic clk;
   logic rst_b;
   int   checkCount;
   int   passCount;
   int   phtWrites;
   int   writesMark;
   logic [1:0] pht [4096];
   logic [HISTORY_LEN-1:0] expGhr;
   logic [HISTORY_LEN-1:0] firstIdx;

   gshare_history_unit_if #(.DEPTH(DEPTH)) bus ();

   gshare_history_unit #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PHT: combinational read, saturating update at the write edge
   assign bus.pht_counter = pht[bus.pht_index];

   function automatic logic [1:0] satUpdate(input logic [1:0] c, input logic taken);
      logic [1:0] n;
      if (taken) begin
         case (c)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            default: n = 2'b10;
         endcase
      end else begin
         case (c)
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
         endcase
      end
      return n;
   endfunction

   always @(posedge clk) begin
      if (bus.pht_write_en) begin
         pht[bus.pht_index] <= satUpdate(pht[bus.pht_index], bus.pht_taken);
         phtWrites++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      else
         passCount++;
   endtask

   task automatic applyStimulus(input logic pv, input logic [HISTORY_LEN-1:0] pc,
                                input logic rv, input logic rt);
      bus.pred_valid    = pv;
      bus.pred_pc       = pc;
      bus.resolve_valid = rv;
      bus.resolve_taken = rt;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // With no resolve pending and pc=0 the index bus shows the GHR directly
   task automatic checkGhr(input string tag, input logic [HISTORY_LEN-1:0] exp);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput(tag, bus.pht_index, exp);
   endtask

   task automatic initPht();
      for (int i = 0; i < 4096; i++) pht[i] <= 2'b01;
   endtask

   // Directed test sequence
   initial begin
      logic [HISTORY_LEN-1:0] pcs3  [4];
      logic [HISTORY_LEN-1:0] idx3  [4];
      logic                   pred3 [4];
      logic [HISTORY_LEN-1:0] pc;

      pcs3  = '{12'h101, 12'h200, 12'h300, 12'h40C};
      idx3  = '{12'h100, 12'h203, 12'h306, 12'h400};
      pred3 = '{1'b1, 1'b0, 1'b0, 1'b1};

      checkCount = 0;
      passCount  = 0;
      phtWrites  = 0;
      rst_b = 1'b1;
      initPht();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      nextCycle();
      nextCycle();

      // Reset behaviour
      applyStimulus(1'b1, 12'h0A3, 1'b1, 1'b1);
      checkOutput("rst_pred_ready", bus.pred_ready, 1'b0);
      checkOutput("rst_write_en", bus.pht_write_en, 1'b0);
      rst_b = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("rst_inflight", bus.inflight, 0);
      checkOutput("rst_mispredict", bus.mispredict, 1'b0);
      checkOutput("rst_ghr", bus.pht_index, 12'h000);
      checkOutput("rst_release_ready", bus.pred_ready, 1'b1);

      // Single prediction then a taken resolve that mispredicts
      applyStimulus(1'b1, 12'h0A3, 1'b0, 1'b0);
      checkOutput("t1_index", bus.pht_index, 12'h0A3);
      checkOutput("t1_pred_taken", bus.pred_taken, 1'b0);
      nextCycle();
      checkGhr("t1_ghr", 12'h000);
      checkOutput("t1_inflight", bus.inflight, 1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("t2_index", bus.pht_index, 12'h0A3);
      checkOutput("t2_write_en", bus.pht_write_en, 1'b1);
      checkOutput("t2_pht_taken", bus.pht_taken, 1'b1);
      checkOutput("t2_ready_blocked", bus.pred_ready, 1'b0);
      nextCycle();
      checkGhr("t2_ghr", 12'h001);
      checkOutput("t2_mispredict", bus.mispredict, 1'b1);
      checkOutput("t2_inflight", bus.inflight, 0);
      checkOutput("t2_counter", pht[12'h0A3], 2'b11);
      applyStimulus(1'b0, 12'h0A2, 1'b0, 1'b0);
      checkOutput("t2_lookup_index", bus.pht_index, 12'h0A3);
      checkOutput("t2_lookup_taken", bus.pred_taken, 1'b1);
      nextCycle();
      checkOutput("t2_pulse_end", bus.mispredict, 1'b0);

      // Four back-to-back predictions, mispredict on the oldest
      initPht();
      pht[12'h100] <= 2'b10;
      pht[12'h400] <= 2'b11;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pcs3[i], 1'b0, 1'b0);
         checkOutput($sformatf("t3_index%0d", i), bus.pht_index, idx3[i]);
         checkOutput($sformatf("t3_pred%0d", i), bus.pred_taken, pred3[i]);
         nextCycle();
      end
      checkGhr("t3_ghr", 12'h019);
      checkOutput("t3_inflight4", bus.inflight, 4);
      writesMark = phtWrites;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t3_res_index", bus.pht_index, 12'h100);
      checkOutput("t3_res_write_en", bus.pht_write_en, 1'b1);
      nextCycle();
      checkGhr("t3_repair_ghr", 12'h002);
      checkOutput("t3_mispredict", bus.mispredict, 1'b1);
      checkOutput("t3_inflight0", bus.inflight, 0);
      checkOutput("t3_write_count", phtWrites - writesMark, 1);
      checkOutput("t3_cnt_100", pht[12'h100], 2'b11);
      checkOutput("t3_cnt_203", pht[12'h203], 2'b01);
      checkOutput("t3_cnt_306", pht[12'h306], 2'b01);
      checkOutput("t3_cnt_400", pht[12'h400], 2'b11);

      // Fill the FIFO, then resolve while fetch is also presenting
      initPht();
      expGhr = 12'h002;
      firstIdx = 12'h010 ^ 12'h002;
      for (int i = 0; i < DEPTH; i++) begin
         pc = 12'(16 * (i + 1));
         applyStimulus(1'b1, pc, 1'b0, 1'b0);
         checkOutput($sformatf("t4_ready%0d", i), bus.pred_ready, 1'b1);
         checkOutput($sformatf("t4_index%0d", i), bus.pht_index, pc ^ expGhr);
         expGhr = {expGhr[HISTORY_LEN-2:0], 1'b0};
         nextCycle();
      end
      applyStimulus(1'b1, 12'h055, 1'b0, 1'b0);
      checkOutput("t4_full_ready", bus.pred_ready, 1'b0);
      checkOutput("t4_full_inflight", bus.inflight, 8);
      nextCycle();
      checkOutput("t4_full_hold", bus.inflight, 8);
      applyStimulus(1'b1, 12'h055, 1'b1, 1'b0);
      checkOutput("t5_ready", bus.pred_ready, 1'b0);
      checkOutput("t5_write_en", bus.pht_write_en, 1'b1);
      checkOutput("t5_head_index", bus.pht_index, firstIdx);
      nextCycle();
      applyStimulus(1'b1, 12'h055, 1'b0, 1'b0);
      checkOutput("t5_inflight7", bus.inflight, 7);
      checkOutput("t5_no_mispredict", bus.mispredict, 1'b0);
      checkOutput("t5_ready_resumes", bus.pred_ready, 1'b1);
      checkOutput("t5_ghr_kept", bus.pht_index, 12'h055 ^ 12'h200);
      nextCycle();
      checkOutput("t5_refill", bus.inflight, 8);

      // Mispredict on the second entry, then a resolve with nothing in flight
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("t6_head_index", bus.pht_index, 12'h024);
      nextCycle();
      checkGhr("t6_repair_ghr", 12'h009);
      checkOutput("t6_mispredict", bus.mispredict, 1'b1);
      checkOutput("t6_inflight0", bus.inflight, 0);
      writesMark = phtWrites;
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("t6_empty_write_en", bus.pht_write_en, 1'b0);
      checkOutput("t6_empty_index", bus.pht_index, 12'h009);
      nextCycle();
      checkGhr("t6_empty_ghr", 12'h009);
      checkOutput("t6_empty_mispredict", bus.mispredict, 1'b0);
      checkOutput("t6_empty_inflight", bus.inflight, 0);
      checkOutput("t6_empty_writes", phtWrites - writesMark, 0);

      // Three in flight, then reset mid-operation
      applyStimulus(1'b1, '0, 1'b0, 1'b0);
      checkOutput("t7_pred0", bus.pred_taken, 1'b0);
      nextCycle();
      applyStimulus(1'b1, '0, 1'b0, 1'b0);
      checkOutput("t7_pred1", bus.pred_taken, 1'b0);
      nextCycle();
      applyStimulus(1'b1, '0, 1'b0, 1'b0);
      checkOutput("t7_pred2", bus.pred_taken, 1'b1);
      nextCycle();
      checkGhr("t7_ghr", 12'h049);
      checkOutput("t7_inflight3", bus.inflight, 3);
      writesMark = phtWrites;
      rst_b = 1'b1;
      applyStimulus(1'b1, '0, 1'b1, 1'b1);
      checkOutput("t7_rst_write_en", bus.pht_write_en, 1'b0);
      checkOutput("t7_rst_ready", bus.pred_ready, 1'b0);
      nextCycle();
      checkGhr("t7_rst_ghr", 12'h000);
      checkOutput("t7_rst_inflight", bus.inflight, 0);
      checkOutput("t7_rst_ready_after", bus.pred_ready, 1'b0);
      checkOutput("t7_rst_writes", phtWrites - writesMark, 0);
      rst_b = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t7_release_ready", bus.pred_ready, 1'b1);
      checkOutput("t7_release_mispredict", bus.mispredict, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
